// File: rtl/operand_fetch_pkg.sv
// Shared CPU datapath constants for the operand-fetch stage and its register file.
package operand_fetch_pkg;

   localparam int DATA_W = 24;
   localparam int NREGS  = 8;
   localparam int ADDR_W = $clog2(NREGS);

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_regfile.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear, r0 reads as zero and ignores writes.
import operand_fetch_pkg::*;

module regfile_2r1w (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // Next register contents: a single write per cycle, never to r0.
   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_addr != REG_ZERO)) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Asynchronous reads; r0 is forced to zero regardless of storage.
   always_comb begin
      rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : regs_q[rd_addr_a];
      rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : regs_q[rd_addr_b];
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file reads with writeback bypass, a single
// registered output buffer with valid/ready handshake, and refresh of held
// operands from writeback while the downstream unit stalls.
import operand_fetch_pkg::*;

module operand_fetch (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [DATA_W-1:0] imm_shamt,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_A,
   output logic [DATA_W-1:0] out_B,
   output logic [DATA_W-1:0] out_shamt
);

   logic [DATA_W-1:0] rf_rd_a;
   logic [DATA_W-1:0] rf_rd_b;
   logic [DATA_W-1:0] fetch_a;
   logic [DATA_W-1:0] fetch_b;
   logic              accept;
   logic              stall;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_a_q, out_a_d;
   logic [DATA_W-1:0] out_b_q, out_b_d;
   logic [DATA_W-1:0] out_shamt_q, out_shamt_d;
   logic [ADDR_W-1:0] rs_cap_q, rs_cap_d;
   logic [ADDR_W-1:0] rt_cap_q, rt_cap_d;

   regfile_2r1w u_regfile (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .rd_addr_a (rs_addr),
      .rd_data_a (rf_rd_a),
      .rd_addr_b (rt_addr),
      .rd_data_b (rf_rd_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   // Handshake and same-cycle writeback bypass (r0 never bypassed).
   always_comb begin
      in_ready = !out_valid_q || out_ready;
      accept   = in_valid && in_ready;
      stall    = out_valid_q && !out_ready;
      fetch_a  = (wr_en && (wr_addr == rs_addr) && (rs_addr != REG_ZERO)) ? wr_data : rf_rd_a;
      fetch_b  = (wr_en && (wr_addr == rt_addr) && (rt_addr != REG_ZERO)) ? wr_data : rf_rd_b;
   end

   // Output buffer next state: accept wins, else refresh on stall, else drain.
   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_shamt_d = out_shamt_q;
      rs_cap_d    = rs_cap_q;
      rt_cap_d    = rt_cap_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_a_d     = fetch_a;
         out_b_d     = fetch_b;
         out_shamt_d = imm_shamt;
         rs_cap_d    = rs_addr;
         rt_cap_d    = rt_addr;
      end else if (stall) begin
         if (wr_en && (wr_addr == rs_cap_q) && (rs_cap_q != REG_ZERO)) begin
            out_a_d = wr_data;
         end
         if (wr_en && (wr_addr == rt_cap_q) && (rt_cap_q != REG_ZERO)) begin
            out_b_d = wr_data;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output buffer registers with asynchronous clear.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_shamt_q <= '0;
         rs_cap_q    <= '0;
         rt_cap_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_shamt_q <= out_shamt_d;
         rs_cap_q    <= rs_cap_d;
         rt_cap_q    <= rt_cap_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_A     = out_a_q;
   assign out_B     = out_b_q;
   assign out_shamt = out_shamt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, bypass, r0, stall refresh,
// consume-vs-refresh ordering, back-to-back throughput and drain.
module tb_operand_fetch;

   localparam int DW = 24;
   localparam int AW = 3;

   logic          clk_sys = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] rs_addr;
   logic [AW-1:0] rt_addr;
   logic [DW-1:0] imm_shamt;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_A;
   logic [DW-1:0] out_B;
   logic [DW-1:0] out_shamt;

   int n_cmp = 0;
   int n_err = 0;

   operand_fetch dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .imm_shamt (imm_shamt),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_A     (out_A),
      .out_B     (out_B),
      .out_shamt (out_shamt)
   );

   always #5 clk_sys = ~clk_sys;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      rs_addr   = '0;
      rt_addr   = '0;
      imm_shamt = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      out_ready = 1'b0;
      rst = 1'b1;
      #12;
      rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      n_cmp++; if (out_A !== 24'h0) begin n_err++; $display("FAIL reset_outA got=%06h exp=000000", out_A); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_reset_mid_transfer();
      tick();
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h00ABCD;
      tick();
      wr_en = 1'b0;
      in_valid = 1'b1; rs_addr = 3'd1; rt_addr = 3'd0; imm_shamt = 24'd3; out_ready = 1'b0;
      tick();
      n_cmp++; if (out_A !== 24'h00ABCD) begin n_err++; $display("FAIL mid_pre_outA got=%06h exp=00abcd", out_A); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got=%0b exp=1", out_valid); end
      #3;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%0b exp=0", out_valid); end
      n_cmp++; if (out_A !== 24'h0) begin n_err++; $display("FAIL mid_rst_outA got=%06h exp=000000", out_A); end
      n_cmp++; if (out_shamt !== 24'h0) begin n_err++; $display("FAIL mid_rst_shamt got=%06h exp=000000", out_shamt); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_in_ready got=%0b exp=1", in_ready); end
      tick();
      in_valid = 1'b1; rs_addr = 3'd1; rt_addr = 3'd0; imm_shamt = 24'd0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_A !== 24'h0) begin n_err++; $display("FAIL mid_r1_cleared got=%06h exp=000000", out_A); end
      tick();
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 24'h123456;
      in_valid = 1'b1; rs_addr = 3'd3; rt_addr = 3'd0; imm_shamt = 24'd4;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (out_A !== 24'h123456) begin n_err++; $display("FAIL bypass_outA got=%06h exp=123456", out_A); end
      n_cmp++; if (out_B !== 24'h0) begin n_err++; $display("FAIL bypass_outB got=%06h exp=000000", out_B); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid got=%0b exp=1", out_valid); end
      rs_addr = 3'd0; rt_addr = 3'd3;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_B !== 24'h123456) begin n_err++; $display("FAIL bypass_stored got=%06h exp=123456", out_B); end
      tick();
   endtask

   task automatic test_r0();
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hFFFFFF;
      in_valid = 1'b1; rs_addr = 3'd0; rt_addr = 3'd0; imm_shamt = 24'd0;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (out_A !== 24'h0) begin n_err++; $display("FAIL r0_nobypass_A got=%06h exp=000000", out_A); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_A !== 24'h0) begin n_err++; $display("FAIL r0_read_A got=%06h exp=000000", out_A); end
      n_cmp++; if (out_B !== 24'h0) begin n_err++; $display("FAIL r0_read_B got=%06h exp=000000", out_B); end
      tick();
   endtask

   task automatic test_stall_refresh();
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h000005;
      tick();
      wr_en = 1'b0;
      in_valid = 1'b1; rs_addr = 3'd2; rt_addr = 3'd3; imm_shamt = 24'd7; out_ready = 1'b0;
      tick();
      n_cmp++; if (out_A !== 24'h000005) begin n_err++; $display("FAIL stall_cap_A got=%06h exp=000005", out_A); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready0 got=%0b exp=0", in_ready); end
      rs_addr = 3'd3; imm_shamt = 24'd9;
      tick();
      n_cmp++; if (out_A !== 24'h000005) begin n_err++; $display("FAIL stall_hold_A got=%06h exp=000005", out_A); end
      n_cmp++; if (out_shamt !== 24'd7) begin n_err++; $display("FAIL stall_hold_shamt got=%0d exp=7", out_shamt); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready1 got=%0b exp=0", in_ready); end
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h000009;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (out_A !== 24'h000009) begin n_err++; $display("FAIL stall_refresh_A got=%06h exp=000009", out_A); end
      n_cmp++; if (out_B !== 24'h123456) begin n_err++; $display("FAIL stall_keep_B got=%06h exp=123456", out_B); end
      n_cmp++; if (out_shamt !== 24'd7) begin n_err++; $display("FAIL stall_shamt2 got=%0d exp=7", out_shamt); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready2 got=%0b exp=0", in_ready); end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (out_A !== 24'h000009) begin n_err++; $display("FAIL stall_after_A got=%06h exp=000009", out_A); end
      // Consume edge with a write to the captured rs: departing set is not refreshed.
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'hAAAAAA;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL consume_valid got=%0b exp=0", out_valid); end
      n_cmp++; if (out_A !== 24'h000009) begin n_err++; $display("FAIL consume_norefresh got=%06h exp=000009", out_A); end
   endtask

   task automatic test_refresh_same_reg();
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'h000011;
      tick();
      wr_en = 1'b0;
      in_valid = 1'b1; rs_addr = 3'd5; rt_addr = 3'd5; imm_shamt = 24'd2; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_B !== 24'h000011) begin n_err++; $display("FAIL same_cap_B got=%06h exp=000011", out_B); end
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 24'h000022;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (out_A !== 24'h000022) begin n_err++; $display("FAIL same_refresh_A got=%06h exp=000022", out_A); end
      n_cmp++; if (out_B !== 24'h000022) begin n_err++; $display("FAIL same_refresh_B got=%06h exp=000022", out_B); end
      // Write to r0 while stalled with r0 captured must not refresh.
      out_ready = 1'b1;
      tick();
      in_valid = 1'b1; rs_addr = 3'd0; rt_addr = 3'd0; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'h0BEEF0;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (out_A !== 24'h0) begin n_err++; $display("FAIL r0_norefresh got=%06h exp=000000", out_A); end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] shamts [4];
      shamts[0] = 24'd1; shamts[1] = 24'd2; shamts[2] = 24'd3; shamts[3] = 24'd24;
      out_ready = 1'b1;
      in_valid  = 1'b1; rs_addr = 3'd3; rt_addr = 3'd5;
      for (int i = 0; i < 4; i++) begin
         imm_shamt = shamts[i];
         tick();
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, out_valid); end
         n_cmp++; if (out_shamt !== shamts[i]) begin n_err++; $display("FAIL b2b_shamt[%0d] got=%0d exp=%0d", i, out_shamt, shamts[i]); end
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, in_ready); end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got=%0b exp=0", out_valid); end
      n_cmp++; if (out_shamt !== 24'd24) begin n_err++; $display("FAIL b2b_end_shamt got=%0d exp=24", out_shamt); end
   endtask

   task automatic test_drain();
      out_ready = 1'b1;
      in_valid = 1'b1; rs_addr = 3'd3; rt_addr = 3'd0; imm_shamt = 24'd5;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid1 got=%0b exp=1", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid0 got=%0b exp=0", out_valid); end
      n_cmp++; if (out_A !== 24'h123456) begin n_err++; $display("FAIL drain_hold_A got=%06h exp=123456", out_A); end
      n_cmp++; if (out_shamt !== 24'd5) begin n_err++; $display("FAIL drain_hold_shamt got=%0d exp=5", out_shamt); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_stays0 got=%0b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_transfer();
      test_bypass();
      test_r0();
      test_stall_refresh();
      test_refresh_same_reg();
      test_back_to_back();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
